// File: rtl/alarm_pkg.sv
// Shared definitions for the multi_alarm engine: channel modes, FSM states
// and calendar constants.
package alarm_pkg;

  localparam int unsigned SECONDS_PER_DAY = 86400;

  typedef enum logic [1:0] {
    ALARM_OFF   = 2'd0,
    ALARM_ONCE  = 2'd1,
    ALARM_DAILY = 2'd2
  } alarm_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } alarm_state_e;

  // Encoding 3 has no meaning and is stored as OFF.
  function automatic alarm_mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return ALARM_ONCE;
      2'd2:    return ALARM_DAILY;
      default: return ALARM_OFF;
    endcase
  endfunction

endpackage

// File: rtl/multi_alarm_if.sv
// Programming/readback port of multi_alarm: channel write and registered
// channel readback for the display path.
interface multi_alarm_if #(
  parameter int unsigned N_ALARMS = 4,
  parameter int unsigned STAMP_W  = 64
);
  localparam int unsigned IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [STAMP_W-1:0] wr_stamp;
  logic [1:0]         wr_mode;
  logic [IDX_W-1:0]   rd_idx;
  logic [STAMP_W-1:0] rd_stamp;
  logic [1:0]         rd_mode;

  modport master (
    output wr_en, wr_idx, wr_stamp, wr_mode, rd_idx,
    input  rd_stamp, rd_mode
  );

  modport slave (
    input  wr_en, wr_idx, wr_stamp, wr_mode, rd_idx,
    output rd_stamp, rd_mode
  );
endinterface

// File: rtl/ring_pattern.sv
// Buzzer cadence generator: one-second period, high for the first half.
// The phase is held at zero while disabled so every ring starts high.
module ring_pattern #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic ring
);
  localparam int unsigned PH_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_HZ - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_HZ / 2);

  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (restart || !enable) begin
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign ring = enable && (phase_q < PH_HALF);

endmodule

// File: rtl/multi_alarm.sv
// N-channel alarm engine: stamp storage, match/consume, ring FSM with
// timeout. Optional snooze support is compiled in by MULTI_ALARM_SNOOZE_EN.
module multi_alarm
  import alarm_pkg::*;
#(
  parameter  int unsigned N_ALARMS       = 4,
  parameter  int unsigned STAMP_W        = 64,
  parameter  int unsigned CLK_HZ         = 50_000_000,
  parameter  int unsigned RING_TIMEOUT_S = 60,
  parameter  int unsigned SNOOZE_S       = 300,
  localparam int unsigned IDX_W          = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STAMP_W-1:0] counter,
  multi_alarm_if.slave       bus,
  input  logic               cancel,
  input  logic               snooze,
  output logic               ring,
  output logic               ringing,
  output logic [IDX_W-1:0]   active_idx
);
  localparam int unsigned TO_W = (RING_TIMEOUT_S > 0) ? $clog2(RING_TIMEOUT_S + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(RING_TIMEOUT_S);

  logic [STAMP_W-1:0] counter_q, counter_d;
  logic [STAMP_W-1:0] stamp_q [N_ALARMS];
  logic [STAMP_W-1:0] stamp_d [N_ALARMS];
  alarm_mode_e        mode_q  [N_ALARMS];
  alarm_mode_e        mode_d  [N_ALARMS];
  logic [STAMP_W-1:0] rd_stamp_q, rd_stamp_d;
  alarm_mode_e        rd_mode_q, rd_mode_d;

  alarm_state_e       state_q, state_d;
  logic [TO_W-1:0]    to_q, to_d, to_inc;
  logic [IDX_W-1:0]   active_q, active_d;

  logic                tick;
  logic [N_ALARMS-1:0] match;
  logic                any_match;
  logic [IDX_W-1:0]    first_idx;
  logic                timeout_hit;
  logic                snooze_req;
  logic                wake;
  logic                pattern_en;
  alarm_mode_e         wr_mode_dec;

  assign counter_d = counter;
  assign tick      = (counter != counter_q);

`ifdef MULTI_ALARM_SNOOZE_EN
  logic [STAMP_W-1:0] deadline_q, deadline_d;

  assign snooze_req = snooze;
  assign wake       = (counter == deadline_q);

  always_comb begin
    deadline_d = deadline_q;
    if (state_q == ST_RINGING && state_d == ST_SNOOZED) begin
      deadline_d = counter + STAMP_W'(SNOOZE_S);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deadline_q <= '0;
    end else begin
      deadline_q <= deadline_d;
    end
  end
`else
  logic unused_snooze;

  assign snooze_req    = 1'b0;
  assign wake          = 1'b0;
  assign unused_snooze = snooze ^ (SNOOZE_S != 0);
`endif

  // Matches are only evaluated on second changes; lowest index owns the ring.
  always_comb begin
    match     = '0;
    first_idx = '0;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      match[i] = tick && (mode_q[i] != ALARM_OFF) && (stamp_q[i] == counter);
    end
    for (int unsigned i = N_ALARMS; i > 0; i--) begin
      if (match[i-1]) first_idx = IDX_W'(i - 1);
    end
    any_match = |match;
  end

  // A same-cycle write replaces the consume update of that channel.
  always_comb begin
    wr_mode_dec = decode_mode(bus.wr_mode);
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      stamp_d[i] = stamp_q[i];
      mode_d[i]  = mode_q[i];
      if (bus.wr_en && (32'(bus.wr_idx) == i)) begin
        stamp_d[i] = bus.wr_stamp;
        mode_d[i]  = wr_mode_dec;
      end else if (match[i]) begin
        case (mode_q[i])
          ALARM_ONCE:  mode_d[i]  = ALARM_OFF;
          ALARM_DAILY: stamp_d[i] = stamp_q[i] + STAMP_W'(SECONDS_PER_DAY);
          default:     mode_d[i]  = mode_q[i];
        endcase
      end
    end
  end

  // Readback samples next-state storage so a write shows one cycle later.
  always_comb begin
    rd_stamp_d = '0;
    rd_mode_d  = ALARM_OFF;
    for (int unsigned i = 0; i < N_ALARMS; i++) begin
      if (32'(bus.rd_idx) == i) begin
        rd_stamp_d = stamp_d[i];
        rd_mode_d  = mode_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q  <= '0;
      rd_stamp_q <= '0;
      rd_mode_q  <= ALARM_OFF;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        stamp_q[i] <= '0;
        mode_q[i]  <= ALARM_OFF;
      end
    end else begin
      counter_q  <= counter_d;
      rd_stamp_q <= rd_stamp_d;
      rd_mode_q  <= rd_mode_d;
      for (int unsigned i = 0; i < N_ALARMS; i++) begin
        stamp_q[i] <= stamp_d[i];
        mode_q[i]  <= mode_d[i];
      end
    end
  end

  assign to_inc      = (to_q == TO_LIMIT) ? to_q : to_q + TO_W'(1);
  assign timeout_hit = tick && (to_inc == TO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (any_match) begin
      state_d = ST_RINGING;
    end else begin
      case (state_q)
        ST_RINGING: begin
          if (cancel || timeout_hit) state_d = ST_IDLE;
          else if (snooze_req)       state_d = ST_SNOOZED;
        end
        ST_SNOOZED: begin
          if (cancel)    state_d = ST_IDLE;
          else if (wake) state_d = ST_RINGING;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ringing    = (state_q != ST_IDLE);
    pattern_en = (state_q == ST_RINGING);
  end

  // Timeout only accumulates while staying in RINGING without a new match.
  always_comb begin
    active_d = any_match ? first_idx : active_q;
    to_d     = '0;
    if (!any_match && state_q == ST_RINGING && state_d == ST_RINGING) begin
      to_d = tick ? to_inc : to_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q     <= '0;
      active_q <= '0;
    end else begin
      to_q     <= to_d;
      active_q <= active_d;
    end
  end

  ring_pattern #(
    .CLK_HZ (CLK_HZ)
  ) u_ring_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (pattern_en),
    .restart (any_match),
    .ring    (ring)
  );

  assign active_idx   = active_q;
  assign bus.rd_stamp = rd_stamp_q;
  assign bus.rd_mode  = rd_mode_q;

endmodule

// File: tb/tb_multi_alarm.sv
// Scoreboard bench for multi_alarm: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model of the alarm rules.
module tb_multi_alarm;
  localparam int unsigned N   = 4;
  localparam int unsigned SW  = 64;
  localparam int unsigned HZ  = 10;
  localparam int unsigned TO  = 5;
  localparam int unsigned SNZ = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] counter;
  logic          cancel, snooze;
  logic          ring, ringing;
  logic [1:0]    active_idx;

  multi_alarm_if #(.N_ALARMS(N), .STAMP_W(SW)) bus ();

  multi_alarm #(
    .N_ALARMS       (N),
    .STAMP_W        (SW),
    .CLK_HZ         (HZ),
    .RING_TIMEOUT_S (TO),
    .SNOOZE_S       (SNZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .counter    (counter),
    .bus        (bus),
    .cancel     (cancel),
    .snooze     (snooze),
    .ring       (ring),
    .ringing    (ringing),
    .active_idx (active_idx)
  );

  always #5 clk = ~clk;

`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif

  typedef struct {
    bit              ring;
    bit              ringing;
    int              active;
    longint unsigned rd_stamp;
    int              rd_mode;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rst_hold;

  // Behavioural model state
  longint unsigned m_stamp [N];
  int              m_mode  [N];
  longint unsigned m_prev;
  string           m_st;
  int              m_cyc;
  int              m_secs;
  longint unsigned m_deadline;
  int              m_active;
  longint unsigned m_rd_stamp;
  int              m_rd_mode;

  task automatic push_exp();
    exp_t e;
    e.ring     = (m_st == "RINGING") && (m_cyc < HZ / 2);
    e.ringing  = (m_st != "IDLE");
    e.active   = m_active;
    e.rd_stamp = m_rd_stamp;
    e.rd_mode  = m_rd_mode;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_stamp[i] = 0;
      m_mode[i]  = 0;
    end
    m_prev = 0; m_st = "IDLE"; m_cyc = 0; m_secs = 0; m_deadline = 0;
    m_active = 0; m_rd_stamp = 0; m_rd_mode = 0;
  endtask

  task automatic model_step(input bit we, input int widx, input longint unsigned wst,
                            input int wmd, input int ridx, input bit can, input bit snz,
                            input longint unsigned ctr);
    int hits[$];
    bit hit [N];
    bit changed;
    changed = (ctr != m_prev);
    for (int i = 0; i < N; i++) begin
      hit[i] = changed && (m_mode[i] != 0) && (m_stamp[i] == ctr);
      if (hit[i]) hits.push_back(i);
    end
    for (int i = 0; i < N; i++) begin
      if (we && widx == i) begin
        m_stamp[i] = wst;
        m_mode[i]  = wmd;
      end else if (hit[i]) begin
        if (m_mode[i] == 1) m_mode[i] = 0;
        else                m_stamp[i] = m_stamp[i] + 86400;
      end
    end
    m_prev     = ctr;
    m_rd_stamp = m_stamp[ridx];
    m_rd_mode  = m_mode[ridx];
    if (hits.size() > 0) begin
      m_st = "RINGING"; m_active = hits[0]; m_cyc = 0; m_secs = 0;
    end else if (m_st == "RINGING") begin
      if (can)                               m_st = "IDLE";
      else if (changed && m_secs + 1 >= TO)  m_st = "IDLE";
      else if (snz && SNOOZE_EN) begin
        m_st = "SNOOZED"; m_deadline = ctr + SNZ;
      end else begin
        m_cyc = (m_cyc + 1) % HZ;
        if (changed) m_secs++;
      end
    end else if (m_st == "SNOOZED") begin
      if (can) m_st = "IDLE";
      else if (ctr == m_deadline) begin
        m_st = "RINGING"; m_cyc = 0; m_secs = 0;
      end
    end
  endtask

  // One clock of stimulus: drive at negedge, predict the post-posedge view.
  task automatic cyc(input bit we, input int widx, input longint unsigned wst,
                     input int wmd, input int ridx, input bit can, input bit snz,
                     input longint unsigned ctr);
    @(negedge clk);
    rst_n        = !rst_hold;
    bus.wr_en    = we;
    bus.wr_idx   = 2'(widx);
    bus.wr_stamp = wst;
    bus.wr_mode  = 2'(wmd);
    bus.rd_idx   = 2'(ridx);
    cancel       = can;
    snooze       = snz;
    counter      = ctr;
    if (rst_hold) begin
      model_reset();
      push_exp();
    end else begin
      model_step(we, widx, wst, wmd, ridx, can, snz, ctr);
      push_exp();
    end
  endtask

  task automatic hold(input int n, input longint unsigned ctr, input int ridx);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 0, ridx, 1'b0, 1'b0, ctr);
  endtask

  task automatic wr(input int idx, input longint unsigned st, input int md,
                    input longint unsigned ctr);
    cyc(1'b1, idx, st, md, idx, 1'b0, 1'b0, ctr);
  endtask

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ring",       64'(ring),         64'(e.ring));
        check("ringing",    64'(ringing),      64'(e.ringing));
        check("active_idx", 64'(active_idx),   64'(e.active));
        check("rd_stamp",   bus.rd_stamp,      e.rd_stamp);
        check("rd_mode",    64'(bus.rd_mode),  64'(e.rd_mode));
      end
    end
  end

  initial begin : driver
    longint unsigned ctr;
    int guard;
    rst_hold = 1'b1;
    rst_n = 1'b0; counter = '0; cancel = 1'b0; snooze = 1'b0;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_stamp = '0; bus.wr_mode = '0; bus.rd_idx = '0;
    model_reset();
    hold(2, 0, 0);
    rst_hold = 1'b0;

    // Basic ONCE on channel 2, full ring pattern, then cancel
    wr(2, 100, 1, 0);
    hold(2, 99, 2);
    hold(14, 100, 2);
    cyc(1'b0, 0, 0, 0, 2, 1'b1, 1'b0, 100);
    hold(2, 100, 2);

    // DAILY on channel 0, match coincides with cancel
    wr(0, 1000, 2, 100);
    hold(2, 999, 0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1000);
    hold(3, 1000, 0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1000);

    // Simultaneous matches on channels 1 and 3
    wr(1, 50, 1, 1000);
    wr(3, 50, 1, 1000);
    hold(2, 49, 3);
    hold(1, 50, 3);
    cyc(1'b0, 0, 0, 0, 1, 1'b1, 1'b0, 50);
    hold(2, 50, 1);

    // Timeout after five second-changes
    wr(1, 500, 1, 50);
    hold(2, 499, 1);
    hold(3, 500, 1);
    for (int k = 1; k <= 5; k++) hold(3, 500 + k, 1);
    hold(2, 505, 1);

    // Snooze (ignored when not compiled in)
    wr(2, 200, 1, 505);
    hold(2, 199, 2);
    hold(3, 200, 2);
    cyc(1'b0, 0, 0, 0, 2, 1'b0, 1'b1, 201);
    hold(3, 201, 2);
    hold(2, 202, 2);
    hold(2, 203, 2);
    hold(4, 204, 2);
    cyc(1'b0, 0, 0, 0, 2, 1'b1, 1'b0, 204);
    hold(2, 204, 2);

    // Reset in the middle of a ring
    wr(3, 600, 2, 204);
    hold(2, 599, 3);
    hold(3, 600, 3);
    rst_hold = 1'b1;
    hold(2, 600, 3);
    rst_hold = 1'b0;
    hold(2, 600, 3);

    // Write/match collision on channel 0
    wr(0, 200, 1, 600);
    hold(2, 199, 0);
    cyc(1'b1, 0, 300, 1, 0, 1'b0, 1'b0, 200);
    hold(3, 200, 0);
    cyc(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 200);

    // Random traffic
    ctr = 5000;
    for (int k = 0; k < 400; k++) begin
      if ($urandom % 3 == 0) ctr++;
      cyc(($urandom % 4) == 0, int'($urandom % 4), ctr + longint'($urandom % 5),
          int'($urandom % 3), int'($urandom % 4), ($urandom % 20) == 0,
          ($urandom % 12) == 0, ctr);
    end
    hold(2, ctr, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm.md
# multi_alarm

Parametrised N-channel alarm engine for the digital clock. It compares the free-running seconds counter against per-channel stamps, each with a one-shot or daily repeat mode. On a match it drives a timed ring pattern with cancel, auto-timeout and optional snooze. It sits beside the time-keeping counter and feeds the buzzer and the alarm display path.

## Interface
- N_ALARMS, 4: number of alarm channels (1..16)
- STAMP_W, 64: width of counter and stamps (seconds)
- CLK_HZ, 50_000_000: clk cycles per second; sets ring pattern period
- RING_TIMEOUT_S, 60: seconds of unattended ringing before auto-stop
- SNOOZE_S, 300: snooze length in seconds (used only with snooze compiled in)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- counter  in  STAMP_W  current time stamp, increments once per second
- wr_en  in  1  write channel wr_idx this cycle
- wr_idx  in  IDX_W=$clog2(N_ALARMS) (min 1)  channel to write
- wr_stamp  in  STAMP_W  new stamp
- wr_mode  in  2  OFF=0, ONCE=1, DAILY=2; 3 treated as OFF
- rd_idx  in  IDX_W  channel to display
- rd_stamp  out  STAMP_W  stored stamp of rd_idx, registered
- rd_mode  out  2  stored mode of rd_idx, registered
- cancel  in  1  stop ringing, level
- snooze  in  1  snooze request, level
- ring  out  1  buzzer drive
- ringing  out  1  high in RINGING or SNOOZED
- active_idx  out  IDX_W  channel that caused the current ring

## Operation
- Storage: per channel, stamp[i] and mode[i]. Reset: all stamps 0, modes OFF.
- Write: wr_en stores wr_stamp and wr_mode into channel wr_idx. Out-of-range idx is ignored.
- Match evaluation: only in cycles where counter != counter_q. counter_q is a registered copy, reset to 0. A channel matches when mode != OFF and stamp == counter.
- Consume on match: ONCE sets the mode to OFF. DAILY sets stamp += 86400, modulo 2^STAMP_W.
- Multiple matches in one cycle: all matched channels are consumed; active_idx takes the lowest matching index.
- Write to a channel in the same cycle it matches: the write wins and no consume update is applied. The match still triggers a ring.
- FSM states IDLE, RINGING, SNOOZED:
  - IDLE -> RINGING on any match.
  - RINGING -> IDLE on cancel, or when the timeout counter reaches RING_TIMEOUT_S second-changes.
  - RINGING -> SNOOZED on snooze (macro only). deadline = counter + SNOOZE_S.
  - SNOOZED -> RINGING when counter == deadline. SNOOZED -> IDLE on cancel.
  - New match in RINGING or SNOOZED -> RINGING. It updates active_idx, restarts the timeout and clears the pattern phase.
  - Match and cancel in the same cycle: the match wins.
- Ring pattern: phase counter 0..CLK_HZ-1, wraps. ring=1 while phase < CLK_HZ/2 in RINGING, otherwise 0. ring=0 in IDLE and SNOOZED.
- Timeout counter width $clog2(RING_TIMEOUT_S+1). It saturates and does not wrap.

## Timing
- Match visible: counter changes in cycle T -> state, ring=1, ringing=1 and active_idx valid at T+1.
- Cancel asserted at T -> ring=0, ringing=0 at T+1.
- Write at T -> rd_stamp/rd_mode reflect it at T+1 if rd_idx==wr_idx. A match at T+1 uses the new value.
- rd_* latency: 1 cycle from rd_idx.
- Reset, including mid-ring: ring=0, ringing=0, active_idx=0, rd_stamp=0, rd_mode=0, state IDLE, all counters 0. Takes effect asynchronously.

## Configuration
- MULTI_ALARM_SNOOZE_EN defined: snooze input is active, SNOOZED state and deadline register exist.
- Not defined: snooze is ignored, no deadline register, SNOOZED is unreachable. Cancel and timeout behave as described above.

## Structure
- Package alarm_pkg: mode encodings (ALARM_OFF, ALARM_ONCE, ALARM_DAILY), FSM state enum, SECONDS_PER_DAY = 86400.
- Sub-module ring_pattern:
  - Inputs: clk, rst_n, enable, restart. Output: ring.
  - Parameter: CLK_HZ.
  - Owns the phase counter.
- Storage, match/consume logic, timeout and FSM live in multi_alarm.

## Test plan
Bench parameters: CLK_HZ=10, N_ALARMS=4, RING_TIMEOUT_S=5, SNOOZE_S=3.
- Basic ONCE: channel 2 set to stamp 100, ONCE; step counter 99->100 -> ring=1 next cycle, active_idx=2, mode[2]=OFF; ring pattern is 5 cycles high, 5 low.
- DAILY: channel 0 set to 1000, DAILY; counter reaches 1000 -> ring; rd_stamp(0)=87400, mode stays DAILY.
- Simultaneous matches: channels 1 and 3 both set to 50 -> active_idx=1; both consumed; cancel at the next cycle -> ring=0, ringing=0.
- Timeout: match, no cancel, 5 counter increments -> IDLE, ring=0.
- Snooze (macro on): ring at 200, snooze at counter 201 -> SNOOZED, ring=0; counter 204 -> RINGING. Macro off: snooze has no effect.
- Reset mid-ring and write/match collision: reset during RINGING clears all outputs. Writing channel 0 = (300, ONCE) in the same cycle channel 0 matches at 200 -> ring=1 and rd_stamp(0)=300, ONCE.
